ibex_lockstep_ctrl: RTL and testbench

//  Sequencing and fault-response controller around the lockstep comparator.
//  - Gates fetch enable until the comparator is live.
//  - Latches comparator mismatches into a sticky fatal state.
//  - Optionally runs a periodic self-test: it injects a forced mismatch and

---
 rtl/ibex_lockstep_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_ibex_lockstep_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_lockstep_ctrl.sv
// ibex_lockstep_ctrl
//   Sequencing and fault-response controller wrapped around the lockstep
//   comparator. It holds fetch off until the shadow core and the comparator
//   are live. It latches comparator mismatches and shadow major alerts into a
//   terminal FAULT state. It can also run a periodic self-test that forces a
//   mismatch and checks that the comparator reports it.
//
//   Build option: define IBEX_LOCKSTEP_SELFTEST_EN to include the periodic
//   self-test (SELFTEST state, period/window counters, cmp_inject_o pulses).
//   Without it, cmp_inject_o and selftest_fail_o are tied low and ACTIVE can
//   only leave to FAULT.
module ibex_lockstep_ctrl #(
   parameter int unsigned LockstepOffset = 2,
   parameter int unsigned SelfTestPeriod = 1024
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic fetch_enable_i,
   output logic fetch_enable_o,
   input  logic core_busy_i,
   input  logic cmp_mismatch_i,
   input  logic shadow_alert_major_i,
   input  logic shadow_alert_minor_i,
   output logic cmp_inject_o,
   output logic lockstep_active_o,
   output logic selftest_fail_o,
   output logic alert_major_o,
   output logic alert_minor_o
);

`ifdef IBEX_LOCKSTEP_SELFTEST_EN
   typedef enum logic [1:0] {
      ST_WARMUP   = 2'd0,
      ST_ACTIVE   = 2'd1,
      ST_SELFTEST = 2'd2,
      ST_FAULT    = 2'd3
   } state_e;
`else
   typedef enum logic [1:0] {
      ST_WARMUP   = 2'd0,
      ST_ACTIVE   = 2'd1,
      ST_FAULT    = 2'd3
   } state_e;
`endif

   // Warm-up covers shadow reset release plus comparator enable.
   localparam int unsigned WarmLen  = LockstepOffset + 2;
   localparam int unsigned WarmW    = $clog2(WarmLen);
   localparam logic [WarmW-1:0] WarmLast = WarmW'(WarmLen - 1);

   // The self-test needs at least a full window plus margin between launches.
   if (SelfTestPeriod < LockstepOffset + 4) begin : g_cfg_check
      $error("SelfTestPeriod must be at least LockstepOffset+4");
   end

`ifdef IBEX_LOCKSTEP_SELFTEST_EN
   // Period counter saturates at SelfTestPeriod-1; window spans the shadow
   // delay plus inject/compare/report latency.
   localparam int unsigned PerW     = (SelfTestPeriod > 1) ? $clog2(SelfTestPeriod) : 1;
   localparam logic [PerW-1:0] PerLast = PerW'(SelfTestPeriod - 1);
   localparam int unsigned WinLen   = LockstepOffset + 3;
   localparam int unsigned WinW     = $clog2(WinLen);
   localparam logic [WinW-1:0] WinLast = WinW'(WinLen - 1);
`endif

   state_e            r_state;
   logic [WarmW-1:0]  r_warm_cnt;
   logic              r_fetch_gate;
   logic              r_active;
   logic              r_alert_major;
   logic              r_alert_minor;

`ifdef IBEX_LOCKSTEP_SELFTEST_EN
   logic [PerW-1:0]   r_period_cnt;
   logic [WinW-1:0]   r_win_cnt;
   logic              r_seen;
   logic              r_inject;
   logic              r_selftest_fail;
`else
   logic              w_unused;
   assign w_unused = core_busy_i;
`endif

   logic w_mismatch_fatal;
   logic w_shadow_fatal;
   logic w_major_trig;

   // Raw mismatches only count while ACTIVE; inside the self-test window they
   // are the expected response. Shadow major alerts count once warm-up is over.
   assign w_mismatch_fatal = (r_state == ST_ACTIVE) && cmp_mismatch_i;
   assign w_shadow_fatal   = (r_state != ST_WARMUP) && shadow_alert_major_i;
   assign w_major_trig     = w_mismatch_fatal || w_shadow_fatal;

   // Main sequencing FSM: state, counters and all registered status outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state         <= ST_WARMUP;
         r_warm_cnt      <= '0;
         r_fetch_gate    <= 1'b0;
         r_active        <= 1'b0;
         r_alert_major   <= 1'b0;
`ifdef IBEX_LOCKSTEP_SELFTEST_EN
         r_period_cnt    <= '0;
         r_win_cnt       <= '0;
         r_seen          <= 1'b0;
         r_inject        <= 1'b0;
         r_selftest_fail <= 1'b0;
`endif
      end else begin
`ifdef IBEX_LOCKSTEP_SELFTEST_EN
         // Inject is a single-cycle pulse unless relaunched below.
         r_inject <= 1'b0;
`endif
         case (r_state)
            ST_WARMUP: begin
               // Fetch stays gated and the comparator is not trusted yet.
               if (r_warm_cnt == WarmLast) begin
                  r_state      <= ST_ACTIVE;
                  r_fetch_gate <= 1'b1;
                  r_active     <= 1'b1;
`ifdef IBEX_LOCKSTEP_SELFTEST_EN
                  r_period_cnt <= '0;
`endif
               end else begin
                  r_warm_cnt <= r_warm_cnt + 1'b1;
               end
            end

            ST_ACTIVE: begin
               // A fatal trigger wins over a pending self-test launch.
               if (w_major_trig) begin
                  r_state       <= ST_FAULT;
                  r_fetch_gate  <= 1'b0;
                  r_active      <= 1'b0;
                  r_alert_major <= 1'b1;
               end
`ifdef IBEX_LOCKSTEP_SELFTEST_EN
               else if (r_period_cnt == PerLast) begin
                  // Period expired: launch only when the core is idle.
                  if (!core_busy_i) begin
                     r_state      <= ST_SELFTEST;
                     r_inject     <= 1'b1;
                     r_period_cnt <= '0;
                     r_win_cnt    <= '0;
                     r_seen       <= 1'b0;
                  end
               end else begin
                  r_period_cnt <= r_period_cnt + 1'b1;
               end
`endif
            end

`ifdef IBEX_LOCKSTEP_SELFTEST_EN
            ST_SELFTEST: begin
               // Mismatches are masked here and only recorded as "seen".
               if (w_major_trig) begin
                  r_state       <= ST_FAULT;
                  r_fetch_gate  <= 1'b0;
                  r_active      <= 1'b0;
                  r_alert_major <= 1'b1;
               end else if (r_win_cnt == WinLast) begin
                  if (r_seen || cmp_mismatch_i) begin
                     r_state <= ST_ACTIVE;
                  end else begin
                     // The comparator failed to flag the forced mismatch.
                     r_state         <= ST_FAULT;
                     r_fetch_gate    <= 1'b0;
                     r_active        <= 1'b0;
                     r_alert_major   <= 1'b1;
                     r_selftest_fail <= 1'b1;
                  end
               end else begin
                  r_win_cnt <= r_win_cnt + 1'b1;
                  r_seen    <= r_seen || cmp_mismatch_i;
               end
            end
`endif

            ST_FAULT: begin
               // Terminal until reset.
               r_fetch_gate  <= 1'b0;
               r_active      <= 1'b0;
               r_alert_major <= 1'b1;
            end

            default: begin
               // Unreachable encoding: fail safe.
               r_state       <= ST_FAULT;
               r_fetch_gate  <= 1'b0;
               r_active      <= 1'b0;
               r_alert_major <= 1'b1;
            end
         endcase
      end
   end

   // Minor alert is only re-timed; it never influences sequencing.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_alert_minor <= 1'b0;
      end else begin
         r_alert_minor <= shadow_alert_minor_i;
      end
   end

   // Gate is registered so fetch drops on the same edge as the major alert.
   assign fetch_enable_o    = fetch_enable_i && r_fetch_gate;
   assign lockstep_active_o = r_active;
   assign alert_major_o     = r_alert_major;
   assign alert_minor_o     = r_alert_minor;

`ifdef IBEX_LOCKSTEP_SELFTEST_EN
   assign cmp_inject_o      = r_inject;
   assign selftest_fail_o   = r_selftest_fail;
`else
   assign cmp_inject_o      = 1'b0;
   assign selftest_fail_o   = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_lockstep_ctrl.sv
// tb_ibex_lockstep_ctrl
//   Randomized bench with an event-time reference model: the model tracks when
//   warm-up ends, when the current self-test period began and when the current
//   window opened, and derives every output from those cycle numbers.
module tb_ibex_lockstep_ctrl;
   localparam int OFF  = 2;
   localparam int PER  = 16;
   localparam int WARM = OFF + 2;
   localparam int WIN  = OFF + 3;

   logic clk    = 1'b0;
   logic rst_n  = 1'b1;
   logic fe_i   = 1'b0;
   logic busy_i = 1'b0;
   logic mm_i   = 1'b0;
   logic smaj_i = 1'b0;
   logic smin_i = 1'b0;
   logic fe_o, inj_o, act_o, stf_o, maj_o, min_o;

   always #5 clk = ~clk;

   ibex_lockstep_ctrl #(
      .LockstepOffset(OFF),
      .SelfTestPeriod(PER)
   ) dut (
      .clk_i               (clk),
      .rst_ni              (rst_n),
      .fetch_enable_i      (fe_i),
      .fetch_enable_o      (fe_o),
      .core_busy_i         (busy_i),
      .cmp_mismatch_i      (mm_i),
      .shadow_alert_major_i(smaj_i),
      .shadow_alert_minor_i(smin_i),
      .cmp_inject_o        (inj_o),
      .lockstep_active_o   (act_o),
      .selftest_fail_o     (stf_o),
      .alert_major_o       (maj_o),
      .alert_minor_o       (min_o)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state (cycle numbers count clock edges since release)
   int cyc       = 0;
   int per_start = 0;
   int win_start = -1;
   int resp_at   = -1;
   bit m_fault   = 0;
   bit m_stfail  = 0;
   bit m_seen    = 0;
   bit m_inj     = 0;
   bit m_min     = 0;

   task automatic check(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      cyc = 0; per_start = 0; win_start = -1; resp_at = -1;
      m_fault = 0; m_stfail = 0; m_seen = 0; m_inj = 0; m_min = 0;
   endtask

   // Advance the model by one clock edge using the inputs held before it.
   task automatic model_edge();
      bit in_win;
      cyc++;
      in_win = (win_start >= 0);
      m_min  = smin_i;
      m_inj  = 0;
      if (!m_fault && cyc == WARM) begin
         per_start = cyc;
      end else if (!m_fault && cyc > WARM) begin
         if (smaj_i || (!in_win && mm_i)) begin
            m_fault = 1;
         end
`ifdef IBEX_LOCKSTEP_SELFTEST_EN
         else if (in_win) begin
            m_seen = m_seen | mm_i;
            if (cyc - win_start == WIN) begin
               if (m_seen) begin
                  win_start = -1;
                  per_start = cyc;
               end else begin
                  m_fault  = 1;
                  m_stfail = 1;
               end
            end
         end else if (cyc - per_start >= PER && !busy_i) begin
            m_inj     = 1;
            win_start = cyc;
            m_seen    = 0;
         end
`endif
      end
   endtask

   task automatic compare_all();
      bit live;
      live = !m_fault && (cyc >= WARM);
      check("fetch_enable_o", fe_o, fe_i & live);
      check("lockstep_active_o", act_o, live);
      check("alert_major_o", maj_o, m_fault);
      check("selftest_fail_o", stf_o, m_stfail);
      check("cmp_inject_o", inj_o, m_inj);
      check("alert_minor_o", min_o, m_min);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic run_to(input int target);
      while (cyc < target) tick();
   endtask

   // Asynchronous reset in the middle of a cycle; outputs must clear at once.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_fetch_enable_o", fe_o, 1'b0);
      check("rst_lockstep_active_o", act_o, 1'b0);
      check("rst_alert_major_o", maj_o, 1'b0);
      check("rst_selftest_fail_o", stf_o, 1'b0);
      check("rst_cmp_inject_o", inj_o, 1'b0);
      check("rst_alert_minor_o", min_o, 1'b0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   task automatic drive_random();
      fe_i   = ($urandom_range(0, 15) != 0);
      smin_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) busy_i = ~busy_i;
      mm_i   = (cyc == resp_at) || ($urandom_range(0, 499) == 0);
      smaj_i = ($urandom_range(0, 799) == 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Warm-up: fetch held off for four cycles, then follows the input
      fe_i = 1'b1;
      do_reset();
      check("s1_fe_at_release", fe_o, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         run_to(k);
         check("s1_fe_warmup", fe_o, 1'b0);
      end
      run_to(4);
      check("s1_fe_live", fe_o, 1'b1);
      check("s1_active_live", act_o, 1'b1);

      // Mismatch in ACTIVE is fatal one cycle later and stays fatal
      run_to(6);
      mm_i = 1'b1;
      run_to(7);
      mm_i = 1'b0;
      check("s2_major_next", maj_o, 1'b1);
      check("s2_fe_drop", fe_o, 1'b0);
      run_to(107);
      check("s2_major_sticky", maj_o, 1'b1);
      check("s2_fe_sticky", fe_o, 1'b0);

`ifdef IBEX_LOCKSTEP_SELFTEST_EN
      // Self-test pass, then self-test fail
      do_reset();
      run_to(19);
      check("s3_no_inject_early", inj_o, 1'b0);
      run_to(20);
      check("s3_inject_at_16", inj_o, 1'b1);
      run_to(23);
      mm_i = 1'b1;
      run_to(24);
      mm_i = 1'b0;
      run_to(25);
      check("s3_no_alert", maj_o, 1'b0);
      check("s3_back_active", act_o, 1'b1);
      run_to(40);
      check("s3_no_inject_before_next", inj_o, 1'b0);
      run_to(41);
      check("s3_next_inject", inj_o, 1'b1);
      run_to(45);
      check("s4_no_fail_before_end", stf_o, 1'b0);
      run_to(46);
      check("s4_selftest_fail", stf_o, 1'b1);
      check("s4_major", maj_o, 1'b1);
      check("s4_fe_drop", fe_o, 1'b0);

      // Busy core postpones the launch
      busy_i = 1'b1;
      do_reset();
      run_to(60);
      check("s5_no_inject_busy", inj_o, 1'b0);
      busy_i = 1'b0;
      run_to(61);
      check("s5_inject_after_idle", inj_o, 1'b1);
      run_to(63);
      do_reset();
      run_to(3);
      check("s6_warm_again", fe_o, 1'b0);
      run_to(4);
      check("s6_live_again", fe_o, 1'b1);
`endif

      // Shadow major alert, then reset from FAULT
      do_reset();
      run_to(6);
      smaj_i = 1'b1;
      run_to(7);
      smaj_i = 1'b0;
      check("s6_shadow_major", maj_o, 1'b1);
      run_to(10);
      do_reset();

      // Randomized segments
      for (int seg = 0; seg < 10; seg++) begin
         do_reset();
         for (int c = 0; c < 300; c++) begin
            drive_random();
            tick();
            if (m_inj && $urandom_range(0, 4) != 0) resp_at = cyc + int'($urandom_range(0, 4));
            if ($urandom_range(0, 299) == 0) do_reset();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
